// File: rtl/alu_out_stage_pkg.sv
// Shared ALU definitions: output-buffer occupancy encodings and flag bit positions.
// Also provides the saturating helper used by the flushed-entry counter.
package alu_out_stage_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGS_W = 4;
  localparam int DROP_W  = 8;

  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] base,
                                                     input logic [1:0] inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, base} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} flag generation for one ALU result word.
module alu_flag_gen
  import alu_out_stage_pkg::*;
#(
  parameter int ancho = 4
) (
  input  logic [ancho-1:0]   aluresult,
  input  logic               carry_in,
  input  logic               ovf_in,
  output logic [FLAGS_W-1:0] flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = aluresult[ancho-1];
    flags[FLAG_Z] = (aluresult == '0);
    flags[FLAG_C] = carry_in;
    flags[FLAG_V] = ovf_in;
  end

endmodule

// File: rtl/alu_out_stage.sv
// Two-entry output buffer for ALU results with flags captured at push time,
// synchronous flush with a saturating dropped-entry counter.
//
// state     | meaning
// OCC_EMPTY | no buffered entry, in_ready=1, out_valid=0
// OCC_ONE   | one entry at rd_ptr, in_ready=1, out_valid=1
// OCC_FULL  | both slots used, in_ready=0, out_valid=1
module alu_out_stage
  import alu_out_stage_pkg::*;
#(
  parameter int ancho = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ancho-1:0]    aluresult,
  input  logic                carry_in,
  input  logic                ovf_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ancho-1:0]    out_result,
  output logic [FLAGS_W-1:0]  out_flags,
  output logic [DROP_W-1:0]   drop_cnt
);

  occ_e                state_q;
  occ_e                state_d;
  logic                wr_ptr;
  logic                rd_ptr;
  logic                push;
  logic                pop;
  logic [1:0]          drop_inc;
  logic [FLAGS_W-1:0]  flags_new;
  logic [ancho-1:0]    data_q [2];
  logic [FLAGS_W-1:0]  flag_q [2];
  logic [DROP_W-1:0]   drop_q;

  alu_flag_gen #(
    .ancho (ancho)
  ) u_flag_gen (
    .aluresult (aluresult),
    .carry_in  (carry_in),
    .ovf_in    (ovf_in),
    .flags     (flags_new)
  );

  // Handshake decoded from registered state only; no out_ready -> in_ready path.
  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q == OCC_ONE) || (state_q == OCC_FULL);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop_inc  = 2'(state_q) + {1'b0, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) state_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state_d = OCC_FULL;
          else if (pop && !push) state_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        flag_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= aluresult;
        flag_q[wr_ptr] <= flags_new;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // A push attempted in the flush cycle counts as dropped too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (flush) begin
      drop_q <= sat_add_drop(drop_q, drop_inc);
    end
  end

  assign drop_cnt   = drop_q;
  assign out_result = out_valid ? data_q[rd_ptr] : '0;
  assign out_flags  = out_valid ? flag_q[rd_ptr] : '0;

endmodule

// File: tb/tb_alu_out_stage.sv
// Directed self-checking bench for alu_out_stage (ancho=4) with hand-computed vectors.
module tb_alu_out_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] aluresult;
  logic       carry_in;
  logic       ovf_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] drop_cnt;

  int vectors = 0;
  int errors  = 0;

  alu_out_stage #(.ancho(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluresult  (aluresult),
    .carry_in   (carry_in),
    .ovf_in     (ovf_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic c, input logic o,
                       input logic ordy, input logic fl);
    in_valid  = v;
    aluresult = r;
    carry_in  = c;
    ovf_in    = o;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_result !== 4'h0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    vectors++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_out_flags got=%b exp=0000", out_flags); end
    vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_zero_flags();
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_out_valid got=%b exp=1", out_valid); end
    vectors++; if (out_result !== 4'h0) begin errors++; $display("FAIL zero_out_result got=%h exp=0", out_result); end
    vectors++; if (out_flags !== 4'b0110) begin errors++; $display("FAIL zero_out_flags got=%b exp=0110", out_flags); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_drain_valid got=%b exp=0", out_valid); end
    vectors++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL zero_drain_flags got=%b exp=0000", out_flags); end
  endtask

  task automatic test_fill_and_drain();
    drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_one_in_ready got=%b exp=1", in_ready); end
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready got=%b exp=0", in_ready); end
    vectors++; if (out_result !== 4'h9) begin errors++; $display("FAIL fill_head got=%h exp=9", out_result); end
    drive(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (out_result !== 4'h9) begin errors++; $display("FAIL fill_hold_result got=%h exp=9", out_result); end
    vectors++; if (out_flags !== 4'b1000) begin errors++; $display("FAIL fill_hold_flags got=%b exp=1000", out_flags); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_hold_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_result !== 4'h3) begin errors++; $display("FAIL drain_second_result got=%h exp=3", out_result); end
    vectors++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL drain_second_flags got=%b exp=0000", out_flags); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_second_valid got=%b exp=1", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got=%b exp=0 (third push leaked)", out_valid); end
    vectors++; if (out_result !== 4'h0) begin errors++; $display("FAIL drain_empty_result got=%h exp=0", out_result); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++; if (out_result !== 4'h5) begin errors++; $display("FAIL simul_first got=%h exp=5", out_result); end
    drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got=%b exp=1", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_result !== 4'hA) begin errors++; $display("FAIL simul_result got=%h exp=a", out_result); end
    vectors++; if (out_flags !== 4'b1011) begin errors++; $display("FAIL simul_flags got=%b exp=1011", out_flags); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_ignore();
    drive(1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid got=%b exp=0", out_valid); end
    vectors++; if (out_result !== 4'h0) begin errors++; $display("FAIL ignore_result got=%h exp=0", out_result); end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    aluresult = 4'h2;
    step();
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_in_ready got=%b exp=1", in_ready); end
    vectors++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL flush_full_drop got=%0d exp=2", drop_cnt); end
    drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL flush_one_push_drop got=%0d exp=4", drop_cnt); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid got=%b exp=0", out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL flush_empty_drop got=%0d exp=4", drop_cnt); end
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (out_result !== 4'h6) begin errors++; $display("FAIL flush_reuse_result got=%h exp=6", out_result); end
    step();
  endtask

  task automatic test_saturate();
    int exp_drop;
    exp_drop = 4;
    for (int i = 0; i < 130; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
      vectors++;
      if (drop_cnt !== 8'(exp_drop)) begin
        errors++;
        $display("FAIL saturate_iter%0d got=%0d exp=%0d", i, drop_cnt, exp_drop);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    aluresult = 4'hD;
    step();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_pre_full got=%b exp=0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_result !== 4'h0) begin errors++; $display("FAIL areset_result got=%h exp=0", out_result); end
    vectors++; if (out_flags !== 4'h0) begin errors++; $display("FAIL areset_flags got=%b exp=0000", out_flags); end
    vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL areset_drop got=%0d exp=0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    vectors++; if (out_result !== 4'h8) begin errors++; $display("FAIL areset_first_push got=%h exp=8", out_result); end
    vectors++; if (out_flags !== 4'b1001) begin errors++; $display("FAIL areset_first_flags got=%b exp=1001", out_flags); end
    vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL areset_drop_after got=%0d exp=0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_flags();
    test_fill_and_drain();
    test_simultaneous();
    test_ignore();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
